// File: rtl/lhs_pkg.sv
// Shared types for the ALU LHS shift sequencer: operation codes and sequencer states.
package lhs_pkg;

    typedef enum logic [1:0] {
        PASS = 2'b00,
        SHL  = 2'b01,
        SHR  = 2'b10,
        ZERO = 2'b11
    } lhs_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } seq_state_t;

    function automatic logic is_shift_op(input lhs_op_t op);
        return (op == SHL) || (op == SHR);
    endfunction

endpackage

// File: rtl/lhs_shift_seq_if.sv
// Command/result bundle between the microcode controller (master) and the
// LHS shift sequencer (slave).
interface lhs_shift_seq_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 4
);

    logic               start;
    logic [1:0]         operation;
    logic [COUNT_W-1:0] count;
    logic [WIDTH-1:0]   in;
    logic               carry_in;
    logic [WIDTH-1:0]   out;
    logic               carry_out;
    logic               busy;
    logic               done;

    modport master (
        output start, operation, count, in, carry_in,
        input  out, carry_out, busy, done
    );

    modport slave (
        input  start, operation, count, in, carry_in,
        output out, carry_out, busy, done
    );

endinterface

// File: rtl/lhs_step.sv
// Combinational single-bit LHS step: pass, rotate-through-carry left/right, or clear.
module lhs_step
    import lhs_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  lhs_op_t          op,
    input  logic [WIDTH-1:0] d,
    input  logic             c,
    output logic [WIDTH-1:0] q,
    output logic             cq
);

    always_comb begin
        q  = d;
        cq = c;
        unique case (op)
            PASS: begin
                q  = d;
                cq = c;
            end
            SHL: begin
                q  = {d[WIDTH-2:0], c};
                cq = d[WIDTH-1];
            end
            SHR: begin
                q  = {c, d[WIDTH-1:1]};
                cq = d[0];
            end
            ZERO: begin
                q  = '0;
                cq = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lhs_shift_seq.sv
// Multi-bit shift sequencer: one command per start, one LHS step per clock,
// busy while stepping and a one-cycle done pulse when out/carry_out are final.
module lhs_shift_seq
    import lhs_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 4
) (
    input logic            clk,
    input logic            reset,
    lhs_shift_seq_if.slave bus
);

    seq_state_t         state_q;
    seq_state_t         state_d;
    lhs_op_t            cmd_op;
    lhs_op_t            op_q;
    lhs_op_t            step_op;
    logic [WIDTH-1:0]   out_q;
    logic               carry_q;
    logic [COUNT_W-1:0] remaining_q;
    logic [WIDTH-1:0]   step_d;
    logic               step_c;
    logic [WIDTH-1:0]   step_q;
    logic               step_cq;
    logic               accept;
    logic               needs_shift;

    assign cmd_op      = lhs_op_t'(bus.operation);
    assign accept      = (state_q == IDLE) && bus.start;
    assign needs_shift = is_shift_op(cmd_op) && (bus.count != '0);

    // The accepting edge reuses the step unit as PASS/ZERO on the raw operand,
    // so a shift command first loads in/carry_in and steps from the next edge.
    always_comb begin
        step_op = op_q;
        step_d  = out_q;
        step_c  = carry_q;
        if (state_q == IDLE) begin
            step_op = (cmd_op == ZERO) ? ZERO : PASS;
            step_d  = bus.in;
            step_c  = bus.carry_in;
        end
    end

    lhs_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .op(step_op),
        .d (step_d),
        .c (step_c),
        .q (step_q),
        .cq(step_cq)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = needs_shift ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (remaining_q == COUNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            carry_q     <= 1'b0;
            remaining_q <= '0;
            op_q        <= PASS;
        end else if (accept) begin
            out_q       <= step_q;
            carry_q     <= step_cq;
            remaining_q <= bus.count;
            op_q        <= cmd_op;
        end else if (state_q == SHIFT) begin
            out_q       <= step_q;
            carry_q     <= step_cq;
            remaining_q <= remaining_q - COUNT_W'(1);
        end
    end

    always_comb begin
        bus.busy      = (state_q == SHIFT);
        bus.done      = (state_q == DONE);
        bus.out       = out_q;
        bus.carry_out = carry_q;
    end

endmodule

// File: tb/tb_lhs_shift_seq.sv
// Self-checking bench for lhs_shift_seq: directed vector table, randomized
// commands against a rotation model, and a reset-during-shift sequence.
module tb_lhs_shift_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    lhs_shift_seq_if #(.WIDTH(W), .COUNT_W(CW)) bus ();

    lhs_shift_seq #(
        .WIDTH  (W),
        .COUNT_W(CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [7:0] d;
        logic       c;
        logic [3:0] n;
        logic [7:0] exp_out;
        logic       exp_c;
        int         exp_edges;
        int         exp_busy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: a shift of n steps is a rotation of the (W+1)-bit word {c,d}.
    function automatic void model(input int op, input int d, input int c, input int n,
                                  output int rd, output int rc, output int edges, output int busy);
        int w;
        int k;
        w = (c << W) | d;
        rd = d; rc = c; edges = 1; busy = 0;
        if (op == 3) begin
            rd = 0; rc = 0;
        end else if ((op == 1 || op == 2) && n != 0) begin
            k = n % (W + 1);
            if (op == 2) k = (W + 1 - k) % (W + 1);
            w = ((w << k) | (w >> (W + 1 - k))) & ((1 << (W + 1)) - 1);
            rd = w & ((1 << W) - 1);
            rc = (w >> W) & 1;
            edges = n + 1;
            busy = n;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the IDLE cycle right after DONE.
    task automatic run_cmd(input string name, input logic [1:0] op, input logic [7:0] d,
                           input logic c, input logic [3:0] n, input logic [7:0] exp_out,
                           input logic exp_c, input int exp_edges, input int exp_busy);
        int   edges;
        int   busy_cyc;
        logic overlap;
        bus.start = 1'b1; bus.operation = op; bus.in = d; bus.carry_in = c; bus.count = n;
        edges = 0; busy_cyc = 0; overlap = 1'b0;
        @(posedge clk); edges++;
        @(negedge clk);
        while (!bus.done && edges < 40) begin
            if (bus.busy) busy_cyc++;
            bus.start = 1'($urandom_range(0, 1));
            bus.operation = 2'($urandom); bus.in = 8'($urandom);
            bus.carry_in = 1'($urandom); bus.count = 4'($urandom);
            @(posedge clk); edges++;
            @(negedge clk);
        end
        overlap = bus.busy & bus.done;
        check({name, " done_edges"}, edges, exp_edges);
        check({name, " busy_cycles"}, busy_cyc, exp_busy);
        check({name, " busy_done_overlap"}, {31'b0, overlap}, 0);
        check({name, " out"}, {24'b0, bus.out}, {24'b0, exp_out});
        check({name, " carry_out"}, {31'b0, bus.carry_out}, {31'b0, exp_c});
        // start during DONE must be ignored
        bus.start = 1'($urandom_range(0, 1));
        bus.operation = 2'b11; bus.in = 8'($urandom);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " done_pulse_ends"}, {31'b0, bus.done}, 0);
        check({name, " idle_not_busy"}, {31'b0, bus.busy}, 0);
        check({name, " out_held"}, {24'b0, bus.out}, {24'b0, exp_out});
        check({name, " carry_held"}, {31'b0, bus.carry_out}, {31'b0, exp_c});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd, rc, re, rb;
        logic [1:0] op;
        logic [7:0] d;
        logic       c;
        logic [3:0] n;

        errors = 0;
        checks = 0;
        vecs[0] = '{2'b01, 8'hAA, 1'b0, 4'd1,  8'h54, 1'b1, 2,  1};
        vecs[1] = '{2'b10, 8'h55, 1'b1, 4'd1,  8'hAA, 1'b1, 2,  1};
        vecs[2] = '{2'b01, 8'h81, 1'b0, 4'd3,  8'h0A, 1'b0, 4,  3};
        vecs[3] = '{2'b10, 8'h3C, 1'b1, 4'd9,  8'h3C, 1'b1, 10, 9};
        vecs[4] = '{2'b11, 8'h55, 1'b1, 4'd5,  8'h00, 1'b0, 1,  0};
        vecs[5] = '{2'b00, 8'hFF, 1'b0, 4'd7,  8'hFF, 1'b0, 1,  0};
        vecs[6] = '{2'b01, 8'h5A, 1'b1, 4'd0,  8'h5A, 1'b1, 1,  0};
        vecs[7] = '{2'b01, 8'h81, 1'b0, 4'd10, 8'h02, 1'b1, 11, 10};
        vecs[8] = '{2'b01, 8'h81, 1'b0, 4'd15, 8'h50, 1'b0, 16, 15};
        vecs[9] = '{2'b10, 8'h01, 1'b0, 4'd1,  8'h00, 1'b1, 2,  1};

        reset = 1'b0;
        bus.start = 1'b0; bus.operation = 2'b00; bus.in = 8'h00; bus.carry_in = 1'b0; bus.count = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset out", {24'b0, bus.out}, 0);
        check("reset carry_out", {31'b0, bus.carry_out}, 0);
        check("reset busy", {31'b0, bus.busy}, 0);
        check("reset done", {31'b0, bus.done}, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].d, vecs[i].c, vecs[i].n,
                    vecs[i].exp_out, vecs[i].exp_c, vecs[i].exp_edges, vecs[i].exp_busy);
        end

        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom); d = 8'($urandom); c = 1'($urandom); n = 4'($urandom);
            model(int'(op), int'(d), int'(c), int'(n), rd, rc, re, rb);
            run_cmd($sformatf("rand%0d", i), op, d, c, n, 8'(rd), 1'(rc), re, rb);
        end

        // SHL by 6: stray start at step 2, then asynchronous reset at step 4.
        bus.start = 1'b1; bus.operation = 2'b01; bus.in = 8'h81; bus.carry_in = 1'b0; bus.count = 4'd6;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.operation = 2'b11; bus.count = 4'd1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("seq6 ignored_start busy", {31'b0, bus.busy}, 1);
        check("seq6 ignored_start done", {31'b0, bus.done}, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("seq6 reset out", {24'b0, bus.out}, 0);
        check("seq6 reset carry_out", {31'b0, bus.carry_out}, 0);
        check("seq6 reset busy", {31'b0, bus.busy}, 0);
        check("seq6 reset done", {31'b0, bus.done}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_cmd("seq6 after_reset", 2'b10, 8'h3C, 1'b0, 4'd2, 8'h0F, 1'b0, 3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
